// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: one-bit-per-cycle shift-add multiplier and restoring divider.
// Results are produced 32 cycles after start; divide-by-zero and signed overflow finish in one cycle.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       md_op,
   input  logic [WIDTH-1:0] operand1,
   input  logic [WIDTH-1:0] operand2,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] md_out
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [5:0]       LAST_CNT = 6'(WIDTH - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [2:0]         r_op;
   logic               r_neg;
   logic [5:0]         r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic               r_done;
   logic [WIDTH-1:0]   r_md_out;

   logic               w_accept;
   logic               w_is_div;
   logic               w_sgn1;
   logic               w_sgn2;
   logic               w_neg1;
   logic               w_neg2;
   logic [WIDTH-1:0]   w_mag1;
   logic [WIDTH-1:0]   w_mag2;
   logic               w_div0;
   logic               w_ovf;
   logic               w_special;
   logic [WIDTH-1:0]   w_spec_res;
   logic               w_res_neg;
   logic [2*WIDTH-1:0] w_mul_acc;
   logic [WIDTH:0]     w_rem_sh;
   logic [WIDTH:0]     w_diff;
   logic [2*WIDTH-1:0] w_div_acc;
   logic [2*WIDTH-1:0] w_acc_nxt;
   logic               w_last;

   // Sign correction and result selection once the 32 iterations are done.
   function automatic logic [WIDTH-1:0] finalize(input logic [2:0]         op,
                                                 input logic               neg,
                                                 input logic [2*WIDTH-1:0] acc);
      logic [2*WIDTH-1:0] prod;
      logic [WIDTH-1:0]   quo;
      logic [WIDTH-1:0]   res;
      prod = neg ? -acc : acc;
      quo  = op[1] ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
      if (op[2])
         res = neg ? -quo : quo;
      else if (op[1:0] == 2'b00)
         res = prod[WIDTH-1:0];
      else
         res = prod[2*WIDTH-1:WIDTH];
      return res;
   endfunction

   always_comb begin
      w_accept   = (r_state != S_CALC) && start && !flush;
      w_is_div   = md_op[2];
      w_sgn1     = w_is_div ? !md_op[0] : (md_op[1:0] != 2'b11);
      w_sgn2     = w_is_div ? !md_op[0] : !md_op[1];
      w_neg1     = w_sgn1 && operand1[WIDTH-1];
      w_neg2     = w_sgn2 && operand2[WIDTH-1];
      w_mag1     = w_neg1 ? -operand1 : operand1;
      w_mag2     = w_neg2 ? -operand2 : operand2;
      w_div0     = w_is_div && (operand2 == '0);
      w_ovf      = w_is_div && !md_op[0] && (operand1 == MIN_NEG) && (operand2 == '1);
      w_special  = w_div0 || w_ovf;
      w_spec_res = w_div0 ? (md_op[1] ? operand1 : '1) : (md_op[1] ? '0 : MIN_NEG);
      // Remainder follows the dividend; product and quotient follow the sign difference.
      w_res_neg  = (w_is_div && md_op[1]) ? w_neg1 : (w_neg1 ^ w_neg2);
   end

   always_comb begin
      w_mul_acc = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
      w_rem_sh  = r_acc[2*WIDTH-1:WIDTH-1];
      w_diff    = w_rem_sh - {1'b0, r_mcand[WIDTH-1:0]};
      w_div_acc = w_diff[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      w_acc_nxt = r_op[2] ? w_div_acc : w_mul_acc;
      w_last    = (r_cnt == LAST_CNT);
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_state_nxt = w_special ? S_DONE : S_CALC;
         S_CALC: if (w_last) w_state_nxt = S_DONE;
         S_DONE: w_state_nxt = w_accept ? (w_special ? S_DONE : S_CALC) : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (flush) w_state_nxt = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op     <= '0;
         r_neg    <= 1'b0;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_done   <= 1'b0;
         r_md_out <= '0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_op     <= md_op;
            r_neg    <= w_res_neg;
            r_cnt    <= '0;
            // Divide keeps {remainder, dividend/quotient} in r_acc and the divisor in r_mcand.
            r_acc    <= w_is_div ? {{WIDTH{1'b0}}, w_mag1} : '0;
            r_mcand  <= w_is_div ? {{WIDTH{1'b0}}, w_mag2} : {{WIDTH{1'b0}}, w_mag1};
            r_mplier <= w_mag2;
            if (w_special) begin
               r_md_out <= w_spec_res;
               r_done   <= 1'b1;
            end
         end else if (r_state == S_CALC && !flush) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_op[2] ? r_mcand : {r_mcand[2*WIDTH-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
            r_cnt    <= r_cnt + 6'd1;
            if (w_last) begin
               r_md_out <= finalize(r_op, r_neg, w_acc_nxt);
               r_done   <= 1'b1;
            end
         end
      end
   end

   assign busy   = (r_state == S_CALC);
   assign done   = r_done;
   assign md_out = r_md_out;

endmodule
